// File: rtl/z85_block_seq.sv
// Block transfer / compare / I/O sequencer for the Z85 core (LDI/CPI/INI/OUTI and
// their decrement and repeat forms), plus the flag helpers those instructions share.
package z85_flags_pkg;

   function automatic logic even_parity(input logic [7:0] v);
      return ~(^v);
   endfunction

   function automatic logic [7:0] flags_ld_block(input logic [7:0] f, input logic [7:0] a,
                                                 input logic [7:0] data, input logic [15:0] bc_after);
      logic [7:0] n;
      n = a + data;
      return {f[7], f[6], n[1], 1'b0, n[3], (bc_after != 16'h0000), 1'b0, f[0]};
   endfunction

   function automatic logic [7:0] flags_cp_block(input logic [7:0] f, input logic [7:0] a,
                                                 input logic [7:0] data, input logic [15:0] bc_after);
      logic [7:0] res;
      logic [7:0] n;
      logic       h;
      res = a - data;
      h   = (a[3:0] < data[3:0]);
      n   = res - {7'd0, h};
      return {res[7], (res == 8'h00), n[1], h, n[3], (bc_after != 16'h0000), 1'b1, f[0]};
   endfunction

   // k mixes the transferred byte with C+/-1 (input) or the new L (output)
   function automatic logic [7:0] flags_block_io(input logic [7:0] data, input logic [7:0] b_after,
                                                 input logic [7:0] c, input logic [7:0] l_after,
                                                 input logic is_in, input logic inc);
      logic [7:0] c_adj;
      logic [8:0] k;
      c_adj = inc ? c + 8'd1 : c - 8'd1;
      k     = {1'b0, data} + {1'b0, (is_in ? c_adj : l_after)};
      return {b_after[7], (b_after == 8'h00), b_after[5], k[8], b_after[3],
              even_parity({5'd0, k[2:0]} ^ b_after), data[7], k[8]};
   endfunction

endpackage

// state | meaning
// IDLE  | waiting for start
// RD    | read request outstanding (mem[HL] or io[BC])
// WR    | write request outstanding (mem[DE], mem[HL] or io[{B-1,C}])
// FIN   | iteration committed; done pulse or loop back to RD
module z85_block_seq
   import z85_flags_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [7:0]  a_in,
   input  logic [7:0]  f_in,
   input  logic [15:0] bc_in,
   input  logic [15:0] de_in,
   input  logic [15:0] hl_in,
   input  logic        irq_pending,
   output logic        bus_req,
   output logic        bus_we,
   output logic        bus_io,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_wdata,
   input  logic        bus_ack,
   input  logic [7:0]  bus_rdata,
   output logic        busy,
   output logic        done,
   output logic        rep_pending,
   output logic [15:0] bc_o,
   output logic [15:0] de_o,
   output logic [15:0] hl_o,
   output logic [7:0]  f_o
);

   typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

   localparam logic [1:0] K_LD  = 2'b00;
   localparam logic [1:0] K_CP  = 2'b01;
   localparam logic [1:0] K_IN  = 2'b10;
   localparam logic [1:0] K_OUT = 2'b11;

   state_t      state;
   logic [1:0]  kind_q;
   logic        dec_q;
   logic        rep_q;
   logic        cont_q;
   logic [7:0]  a_q;
   logic [7:0]  data_q;

   logic [7:0]  byte_now;
   logic [7:0]  cp_res;
   logic [15:0] hl_nx;
   logic [15:0] de_nx;
   logic [15:0] bc_nx;
   logic [7:0]  f_nx;
   logic        cont_nx;
   logic        last_xfer;

   function automatic logic [15:0] rd_addr(input logic [1:0] kind, input logic [15:0] bc,
                                           input logic [15:0] hl);
      return (kind == K_IN) ? bc : hl;
   endfunction

   assign busy      = (state != IDLE);
   assign last_xfer = bus_ack && ((state == WR) || ((state == RD) && (kind_q == K_CP)));

   // CP commits on the read ack, so its byte comes straight off the bus
   always_comb begin
      byte_now = (kind_q == K_CP) ? bus_rdata : data_q;
      cp_res   = a_q - byte_now;
      hl_nx    = dec_q ? hl_o - 16'd1 : hl_o + 16'd1;
      de_nx    = de_o;
      bc_nx    = {bc_o[15:8] - 8'd1, bc_o[7:0]};
      f_nx     = flags_block_io(byte_now, bc_nx[15:8], bc_o[7:0], hl_nx[7:0],
                                (kind_q == K_IN), !dec_q);
      cont_nx  = rep_q && (bc_nx[15:8] != 8'h00);
      case (kind_q)
         K_LD: begin
            de_nx   = dec_q ? de_o - 16'd1 : de_o + 16'd1;
            bc_nx   = bc_o - 16'd1;
            f_nx    = flags_ld_block(f_o, a_q, byte_now, bc_nx);
            cont_nx = rep_q && (bc_nx != 16'h0000);
         end
         K_CP: begin
            bc_nx   = bc_o - 16'd1;
            f_nx    = flags_cp_block(f_o, a_q, byte_now, bc_nx);
            cont_nx = rep_q && (bc_nx != 16'h0000) && (cp_res != 8'h00);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         kind_q      <= K_LD;
         dec_q       <= 1'b0;
         rep_q       <= 1'b0;
         cont_q      <= 1'b0;
         a_q         <= 8'h00;
         data_q      <= 8'h00;
         bus_req     <= 1'b0;
         bus_we      <= 1'b0;
         bus_io      <= 1'b0;
         bus_addr    <= 16'h0000;
         bus_wdata   <= 8'h00;
         done        <= 1'b0;
         rep_pending <= 1'b0;
         bc_o        <= 16'h0000;
         de_o        <= 16'h0000;
         hl_o        <= 16'h0000;
         f_o         <= 8'h00;
      end else begin
         done        <= 1'b0;
         rep_pending <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  kind_q   <= op[3:2];
                  dec_q    <= op[1];
                  rep_q    <= op[0];
                  a_q      <= a_in;
                  f_o      <= f_in;
                  bc_o     <= bc_in;
                  de_o     <= de_in;
                  hl_o     <= hl_in;
                  bus_req  <= 1'b1;
                  bus_we   <= 1'b0;
                  bus_io   <= (op[3:2] == K_IN);
                  bus_addr <= rd_addr(op[3:2], bc_in, hl_in);
                  state    <= RD;
               end
            end
            RD: begin
               if (bus_ack) begin
                  data_q <= bus_rdata;
                  if (kind_q == K_CP) begin
                     bus_req <= 1'b0;
                     bus_io  <= 1'b0;
                     state   <= FIN;
                  end else begin
                     bus_we    <= 1'b1;
                     bus_io    <= (kind_q == K_OUT);
                     bus_wdata <= bus_rdata;
                     case (kind_q)
                        K_LD:    bus_addr <= de_o;
                        K_IN:    bus_addr <= hl_o;
                        default: bus_addr <= {bc_o[15:8] - 8'd1, bc_o[7:0]};
                     endcase
                     state <= WR;
                  end
               end
            end
            WR: begin
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  bus_we  <= 1'b0;
                  bus_io  <= 1'b0;
                  state   <= FIN;
               end
            end
            FIN: begin
               if (cont_q) begin
                  bus_req  <= 1'b1;
                  bus_we   <= 1'b0;
                  bus_io   <= (kind_q == K_IN);
                  bus_addr <= rd_addr(kind_q, bc_o, hl_o);
                  state    <= RD;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         // Decide continue vs. done on the commit edge so done is registered in FIN
         if (last_xfer) begin
            bc_o        <= bc_nx;
            de_o        <= de_nx;
            hl_o        <= hl_nx;
            f_o         <= f_nx;
            done        <= !cont_nx || irq_pending;
            rep_pending <= cont_nx && irq_pending;
            cont_q      <= cont_nx && !irq_pending;
         end
      end
   end

endmodule

// File: doc/z85_block_seq.md
Z85_BLOCK_SEQ -- requirements
Module: z85_block_seq

Interface
REQ-001 The module SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to begin a block instruction; sampled only in IDLE
- op  in  4  {kind[1:0] (00 LD, 01 CP, 10 IN, 11 OUT), dec (1 = decrement HL/DE), rep (1 = repeat form)}
- a_in  in  8  accumulator
- f_in  in  8  flags before the instruction
- bc_in, de_in, hl_in  in  16 each  register pairs before the instruction
- irq_pending  in  1  interrupt or NMI waiting; checked between repeat iterations
- bus_req  out  1  bus transfer request
- bus_we  out  1  1 = write
- bus_io  out  1  1 = I/O space, 0 = memory
- bus_addr  out  16  transfer address
- bus_wdata  out  8  write data
- bus_ack  in  1  transfer complete; read data valid this cycle
- bus_rdata  in  8  read data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- rep_pending  out  1  valid with done; 1 = core must rewind PC by 2 and re-fetch
- bc_o, de_o, hl_o  out  16 each  updated pairs, valid from done until the next start
- f_o  out  8  updated flags, same validity as bc_o

Function
REQ-002 States SHALL be IDLE, RD, WR, FIN. All state SHALL be captured from the inputs on the start cycle.
REQ-003 Op sequences:
- LD: RD mem[HL], then WR mem[DE].
- CP: RD mem[HL] only.
- IN: RD io[BC], then WR mem[HL].
- OUT: RD mem[HL], then WR io[{B-1, C}].
REQ-004 Bus handshake: bus_req, bus_we, bus_io, bus_addr and bus_wdata SHALL stay stable from request until the cycle of bus_ack.
- bus_ack may arrive in the same cycle bus_req rises.
- The state SHALL advance on the edge that samples bus_ack.
- bus_ack seen while bus_req is low SHALL be ignored.
REQ-005 Per-iteration register update, all mod 2^16 or mod 2^8 with wrap-around:
- HL +/-1 for every op.
- DE +/-1 for LD only.
- BC-1 for LD and CP.
- B-1 for IN and OUT; C is unchanged.
REQ-006 Flags SHALL come from z85_flags_pkg:
- LD: flags_ld_block(f, A, byte, BC_after).
- CP: flags_cp_block(f, A, byte, BC_after).
- IN/OUT: flags_block_io(byte, B_after, C, L_after, is_in, !dec).
REQ-007 Repeat continues only if rep=1 and the continue condition holds:
- LD: BC_after != 0.
- CP: BC_after != 0 and result != 0.
- IN/OUT: B_after != 0.
REQ-008 If continuing and irq_pending=0, the block SHALL return from FIN directly to RD without pulsing done.
REQ-009 If continuing and irq_pending=1, the block SHALL pulse done with rep_pending=1 and go to IDLE.
REQ-010 If not continuing, the block SHALL pulse done with rep_pending=0.
REQ-011 Latency with zero-wait acks:
- start at cycle 0 -> done at cycle 3 for LD, IN and OUT.
- start at cycle 0 -> done at cycle 2 for CP.
- Each extra repeat iteration adds 3 cycles (2 for CP).
REQ-012 start while busy=1 SHALL be ignored.
REQ-013 Initial BC=0 on LDIR or CPIR SHALL wrap to FFFF and run 65536 iterations; initial B=0 on INIR or OTIR SHALL run 256 iterations.
REQ-014 done and a new start SHALL NOT overlap: start is accepted no earlier than the cycle after done.

Reset
REQ-015 While rst_n=0 the block SHALL be in IDLE, independent of clk.
REQ-016 Outputs during reset SHALL be: bus_req=0, bus_we=0, bus_io=0, bus_addr=0, bus_wdata=0, busy=0, done=0, rep_pending=0, bc_o/de_o/hl_o=0, f_o=0.
REQ-017 Reset asserted mid-transfer SHALL drop bus_req immediately and perform no further register or flag updates.

Verification
REQ-018 LDI: HL=1000, DE=2000, BC=0001, A=00, byte 5A, zero-wait -> mem[2000]=5A; HL=1001, DE=2001, BC=0000; PV=0; done at cycle 3; rep_pending=0.
REQ-019 LDIR: BC=0003, irq_pending=0 -> three RD/WR pairs; single done at cycle 9; BC=0000.
REQ-020 CPIR: A=42, bytes 10, 42 at HL=3000, BC=0005 -> stops after 2 iterations; HL=3002, BC=0003; Z=1, PV=1.
REQ-021 OTIR: B=02, irq_pending raised during the first iteration -> done after iteration 1; rep_pending=1; B=01; port addr high byte = 01.
REQ-022 INI: ack delayed 4 cycles, then rst_n pulsed low during WR -> bus_req falls asynchronously; busy=0; no done.
REQ-023 LDIR with BC=0000 -> 65536 writes, then done; BC=0000; PV=0.
